// File: rtl/voc_pkg.sv
// Shared constants and FSM encoding for the VOC frame averager.
package voc_pkg;

  localparam int unsigned NUM_CH   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LOG2_AVG = 3;
  localparam int unsigned ACC_W    = DATA_W + LOG2_AVG;

  typedef enum logic [1:0] {
    ACCUM,
    FINAL,
    ISSUE
  } state_t;

endpackage

// File: rtl/voc_channel_acc.sv
// One VOC channel: sum of 2^LOG2_AVG samples, fill counter and averaged output.
// AVG_ROUND_EN selects round-half-up averaging instead of truncation.
module voc_channel_acc #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOG2_AVG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add,
  input  logic              fin,
  input  logic [DATA_W-1:0] data,
  output logic              full_c,
  output logic              will_full_c,
  output logic [DATA_W-1:0] avg
);

  localparam int unsigned ACC_W = DATA_W + LOG2_AVG;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << LOG2_AVG;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] avg_sum;

  assign full_c      = (cnt == FULL_CNT);
  assign will_full_c = full_c || (add && (cnt == FULL_CNT - CNT_W'(1)));

`ifdef AVG_ROUND_EN
  // Half an LSB of the average; zero when no averaging takes place.
  localparam logic [SUM_W-1:0] RND = SUM_W'((2 ** LOG2_AVG) / 2);
  assign avg_sum = {1'b0, acc} + RND;
`else
  assign avg_sum = {1'b0, acc};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      avg <= '0;
    end else if (fin) begin
      avg <= DATA_W'(avg_sum >> LOG2_AVG);
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= acc + ACC_W'(data);
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/voc_frame_averager.sv
// Averages tagged VOC samples per channel and hands each full frame to decision_making.
// Optional macro AVG_ROUND_EN: round-half-up averages (default build truncates).
module voc_frame_averager #(
  parameter int unsigned NUM_CH   = voc_pkg::NUM_CH,
  parameter int unsigned DATA_W   = voc_pkg::DATA_W,
  parameter int unsigned LOG2_AVG = voc_pkg::LOG2_AVG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [2:0]        sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              dm_busy,
  output logic              dm_start,
  output logic [DATA_W-1:0] voc1,
  output logic [DATA_W-1:0] voc2,
  output logic [DATA_W-1:0] voc3,
  output logic [DATA_W-1:0] voc4,
  output logic [DATA_W-1:0] voc5,
  output logic [7:0]        frame_cnt,
  output logic              ch_err,
  output logic              dropped
);

  import voc_pkg::*;

  localparam int unsigned CH_W = 3;

  state_t              state;
  state_t              state_nxt;
  logic                accept_c;
  logic                ch_ok_c;
  logic                drop_c;
  logic                fin_c;
  logic [NUM_CH-1:0]   add_c;
  logic [NUM_CH-1:0]   full_c;
  logic [NUM_CH-1:0]   will_full_c;
  logic [DATA_W-1:0]   avg [NUM_CH];

  assign sample_ready = enable && (state == ACCUM);
  assign accept_c     = sample_valid && sample_ready;
  assign ch_ok_c      = (32'(sample_ch) < NUM_CH);
  assign fin_c        = enable && (state == FINAL);
  // Any handshaked sample that no channel absorbed is a drop.
  assign drop_c       = accept_c && !(|add_c);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign add_c[i] = accept_c && (sample_ch == CH_W'(i)) && !full_c[i];

    voc_channel_acc #(
      .DATA_W   (DATA_W),
      .LOG2_AVG (LOG2_AVG)
    ) u_acc (
      .clk         (clk),
      .rst         (rst),
      .add         (add_c[i]),
      .fin         (fin_c),
      .data        (sample_data),
      .full_c      (full_c[i]),
      .will_full_c (will_full_c[i]),
      .avg         (avg[i])
    );
  end

  assign voc1 = avg[0];
  assign voc2 = avg[1];
  assign voc3 = avg[2];
  assign voc4 = avg[3];
  assign voc5 = avg[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // FINAL is entered on the edge that completes the last channel.
  always_comb begin
    state_nxt = state;
    dm_start  = 1'b0;
    unique case (state)
      ACCUM: if (enable && (&will_full_c)) state_nxt = FINAL;
      FINAL: if (enable) state_nxt = ISSUE;
      ISSUE: begin
        if (enable && !dm_busy) begin
          dm_start  = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      ch_err    <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      if (dm_start) frame_cnt <= frame_cnt + 8'd1;
      if (accept_c && !ch_ok_c) ch_err <= 1'b1;
      dropped <= drop_c;
    end
  end

endmodule

// File: tb/tb_voc_frame_averager.sv
// Directed self-checking bench for voc_frame_averager (default LOG2_AVG=3).
module tb_voc_frame_averager;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  sample_ch;
  logic [31:0] sample_data;
  logic        dm_busy;
  logic        dm_start;
  logic [31:0] voc1, voc2, voc3, voc4, voc5;
  logic [7:0]  frame_cnt;
  logic        ch_err;
  logic        dropped;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

  logic [31:0] vals [5][8];
  logic [31:0] expv [5];

  voc_frame_averager dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .dm_busy      (dm_busy),
    .dm_start     (dm_start),
    .voc1         (voc1),
    .voc2         (voc2),
    .voc3         (voc3),
    .voc4         (voc4),
    .voc5         (voc5),
    .frame_cnt    (frame_cnt),
    .ch_err       (ch_err),
    .dropped      (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (dm_start === 1'b1) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vocs(input string tag);
    chk({tag, "_voc1"}, voc1, expv[0]);
    chk({tag, "_voc2"}, voc2, expv[1]);
    chk({tag, "_voc3"}, voc3, expv[2]);
    chk({tag, "_voc4"}, voc4, expv[3]);
    chk({tag, "_voc5"}, voc5, expv[4]);
  endtask

  // One handshake; returns 1 ns after the accepting edge.
  task automatic send(input logic [2:0] ch, input logic [31:0] d);
    int n;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_data  = d;
    n = 0;
    while (sample_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(sample_ready), 32'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic run_frame();
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 5; c++) send(3'(c), vals[c][k]);
  endtask

  task automatic fill_const(input int c, input logic [31:0] v);
    for (int k = 0; k < 8; k++) vals[c][k] = v;
  endtask

  // Completion with dm_busy=0: FINAL, then ISSUE with the start pulse.
  task automatic finish_frame(input string tag, input logic [7:0] exp_cnt);
    chk({tag, "_rdy_final"}, 32'(sample_ready), 32'd0);
    @(posedge clk);
    #1;
    chk_vocs(tag);
    chk({tag, "_start"}, 32'(dm_start), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    chk({tag, "_start_end"}, 32'(dm_start), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b0;
    sample_ch    = '0;
    sample_data  = '0;
    dm_busy      = 1'b0;
    #3;
    chk("rst_voc1", voc1, 32'd0);
    chk("rst_voc5", voc5, 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_ch_err", 32'(ch_err), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_dm_start", 32'(dm_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(sample_ready), 32'd1);

    // 1: all channels 100
    for (int c = 0; c < 5; c++) begin fill_const(c, 32'd100); expv[c] = 32'd100; end
    run_frame();
    chk("t1_voc_before_final", voc1, 32'd0);
    finish_frame("t1", 8'd1);
    chk("t1_start_cnt", 32'(start_cnt), 32'd1);

    // 2: ch0 ramp 0..7 (sum 28), others 10
    for (int k = 0; k < 8; k++) vals[0][k] = 32'(k);
    for (int c = 1; c < 5; c++) begin fill_const(c, 32'd10); expv[c] = 32'd10; end
`ifdef AVG_ROUND_EN
    expv[0] = 32'd4;
`else
    expv[0] = 32'd3;
`endif
    run_frame();
    finish_frame("t2", 8'd2);

    // 3: overfill ch2, then an out-of-range channel
    for (int k = 0; k < 8; k++) send(3'd2, 32'd50);
    chk("t3_no_drop", 32'(dropped), 32'd0);
    send(3'd2, 32'd999);
    chk("t3_drop_full", 32'(dropped), 32'd1);
    chk("t3_err_clear", 32'(ch_err), 32'd0);
    send(3'd6, 32'd777);
    chk("t3_drop_badch", 32'(dropped), 32'd1);
    chk("t3_ch_err", 32'(ch_err), 32'd1);
    for (int k = 0; k < 8; k++) begin
      send(3'd0, 32'd20);
      send(3'd1, 32'd30);
      send(3'd3, 32'd40);
      send(3'd4, 32'(k + 1));
    end
    chk("t3_drop_clear", 32'(dropped), 32'd0);
    expv[0] = 32'd20; expv[1] = 32'd30; expv[2] = 32'd50; expv[3] = 32'd40;
`ifdef AVG_ROUND_EN
    expv[4] = 32'd5;
`else
    expv[4] = 32'd4;
`endif
    finish_frame("t3", 8'd3);
    chk("t3_err_sticky", 32'(ch_err), 32'd1);

    // 4: completion while dm_busy=1 for 20 cycles; ch0 at full scale
    dm_busy = 1'b1;
    fill_const(0, 32'hFFFF_FFFF);
    expv[0] = 32'hFFFF_FFFF;
    for (int c = 1; c < 5; c++) begin fill_const(c, 32'(1000 * c)); expv[c] = 32'(1000 * c); end
    run_frame();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("t4_start_held", 32'(dm_start), 32'd0);
      chk("t4_ready_held", 32'(sample_ready), 32'd0);
    end
    chk("t4_frame_cnt_held", 32'(frame_cnt), 32'd3);
    chk_vocs("t4");
    @(negedge clk);
    dm_busy = 1'b0;
    #1;
    chk("t4_start", 32'(dm_start), 32'd1);
    @(posedge clk);
    #1;
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd4);
    chk("t4_start_end", 32'(dm_start), 32'd0);
    chk("t4_ready", 32'(sample_ready), 32'd1);
    chk("t4_start_cnt", 32'(start_cnt), 32'd4);

    // 5: enable low for 5 cycles in ISSUE
    dm_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin fill_const(c, 32'(c + 1)); expv[c] = 32'(c + 1); end
    run_frame();
    @(posedge clk);
    #1;
    chk_vocs("t5");
    @(negedge clk);
    enable  = 1'b0;
    dm_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_start_off", 32'(dm_start), 32'd0);
      @(negedge clk);
    end
    chk("t5_frame_cnt_held", 32'(frame_cnt), 32'd4);
    enable = 1'b1;
    #1;
    chk("t5_start", 32'(dm_start), 32'd1);
    @(posedge clk);
    #1;
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("t5_start_cnt", 32'(start_cnt), 32'd5);

    // 6: async reset mid-frame discards the partial frame
    for (int k = 0; k < 3; k++) send(3'd0, 32'd5000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_voc1", voc1, 32'd0);
    chk("t6_voc5", voc5, 32'd0);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_ch_err", 32'(ch_err), 32'd0);
    chk("t6_ready", 32'(sample_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin fill_const(c, 32'd60); expv[c] = 32'd60; end
    run_frame();
    finish_frame("t6", 8'd1);
    chk("t6_start_cnt", 32'(start_cnt), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
